// File: rtl/apb_arb_pkg.sv
// Shared types and default widths for the two-requester APB master.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package apb_arb_pkg;

    // Transfer sequencing states of the APB master.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_arb_state_t;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a registered last-grant pointer.
// Latency: grant is combinational from req; pointer updates on the edge after advance.
// Backpressure: none; caller qualifies req and pulses advance when a grant is taken.
//
// Ports: pclk/preset (sync, active-high), req[1:0] requests, advance = grant consumed,
//        grant[1:0] one-hot (all zero when no request).
module rr_arb2 (
    input  logic       pclk,
    input  logic       preset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // 1 = requester 1 was granted last. Reset to 1 so requester 0 wins first contention.
    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign last_grant_d = (advance && (grant != 2'b00)) ? grant[1] : last_grant_q;

    always_ff @(posedge pclk) begin
        if (preset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin accept, SETUP/ACCESS sequencing, error and timeout return.
// Latency: accept T, SETUP T+1, ACCESS T+2.., rsp_valid one cycle after pready (or after TIMEOUT ACCESS cycles).
// Backpressure: req_ready pulses only in IDLE; one transfer in flight, no response backpressure.
//
// Ports: req_* command ports (packed per requester), rsp_* completion pulse + shared rdata/err,
//        p* APB master signals towards a single slave. pclk/preset are sync, active-high.
module apb_master_arb
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);

    localparam int             CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_VAL = CW'(TIMEOUT);

    apb_arb_state_t      state_q;
    logic [CW-1:0]       wcnt_q;
    logic [CW-1:0]       wcnt_d;
    logic [1:0]          gnt_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [1:0]          rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;

    logic [1:0]          arb_req;
    logic [1:0]          grant;
    logic                accept;
    logic                gsel;

    // Requests are only visible to the arbiter in IDLE and out of reset, so req_ready
    // can never pulse while a transfer is in flight or while reset is held.
    assign arb_req = (state_q == IDLE && !preset) ? req_valid : 2'b00;
    assign accept  = (grant != 2'b00);
    assign gsel    = grant[1];
    assign wcnt_d  = wcnt_q + CW'(1);

    rr_arb2 u_arb (
        .pclk    (pclk),
        .preset  (preset),
        .req     (arb_req),
        .advance (accept),
        .grant   (grant)
    );

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            gnt_q       <= 2'b00;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            // rsp_valid is a one-cycle pulse covering exactly the RESP cycle.
            rsp_valid_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        gnt_q    <= grant;
                        pwrite_q <= req_write[gsel];
                        paddr_q  <= gsel ? req_addr[ADDR_W +: ADDR_W]  : req_addr[0 +: ADDR_W];
                        pwdata_q <= gsel ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
                        psel_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    wcnt_q    <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_rdata_q <= pwrite_q ? '0 : prdata;
                        rsp_err_q   <= pslverr;
                        rsp_valid_q <= gnt_q;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= RESP;
                    end else if (wcnt_d == TO_VAL) begin
                        // Slave never answered: this was the TIMEOUT-th ACCESS cycle.
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= gnt_q;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= RESP;
                    end else begin
                        wcnt_q <= wcnt_d;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;

endmodule
